bit_serial_adder: RTL and testbench

Sequential add/subtract unit that runs two WIDTH-bit operands LSB-first through a single 1-bit full-adder cell, keeping the carry in a flip-flop between cycles. It sits directly upstream of the combinational full-adder cell. It owns operand loading, shifting, carry storage, iteration counting and the start/done handshake, and it collects the cell's sum bits into a parallel result. It trades WIDTH cycles of latency for one adder cell instead of a WIDTH-bit ripple chain.

---
 rtl/bsa_pkg.sv | 16 +
 rtl/fa_cell.sv | 14 +
 rtl/bit_serial_adder.sv | 98 +++++++++
 tb/tb_bit_serial_adder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bsa_pkg.sv
// Shared definitions for the bit-serial add/subtract unit: FSM states,
// mode encodings and the default operand width.
package bsa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } bsa_state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int BSA_WIDTH_DEF = 8;

endpackage

// File: rtl/fa_cell.sv
// Purely combinational 1-bit full adder; the only arithmetic cell in the
// bit-serial adder datapath.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first add/subtract of two WIDTH-bit operands through one fa_cell.
// Define BSA_OVERFLOW_EN to add the signed-overflow output ovf.
module bit_serial_adder
    import bsa_pkg::*;
#(
    parameter int WIDTH = BSA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef BSA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] SHIFT = ST_SHIFT;
    localparam logic [1:0] DONE  = ST_DONE;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cell_s;
    logic             cell_c;
    logic             last_bit;

    fa_cell u_fa (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .cin  (carry),
        .s    (cell_s),
        .cout (cell_c)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign busy     = (state == SHIFT);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef BSA_OVERFLOW_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1: the +1 rides in on the carry.
                        a_sh  <= a;
                        b_sh  <= (mode == MODE_SUB) ? ~b : b;
                        carry <= mode;
                        cnt   <= '0;
                        sum   <= '0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= cell_c;
                    sum   <= {cell_s, sum[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        state <= DONE;
                        cout  <= cell_c;
`ifdef BSA_OVERFLOW_EN
                        // carry still holds the carry into the MSB this cycle.
                        ovf   <= carry ^ cell_c;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: arithmetic reference model with a
// result queue, per-cycle output compare, directed and randomized operations.
module tb_bit_serial_adder;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         mode  = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef BSA_OVERFLOW_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Clock / reset
    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef BSA_OVERFLOW_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the add/subtract rules.
    function automatic void predict(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                                    output logic [W-1:0] s, output logic c, output logic v);
        int ux, uy, sx, sy, r, rs;
        ux = x;
        uy = y;
        sx = $signed(x);
        sy = $signed(y);
        if (!m) begin
            r  = ux + uy;
            c  = (r >= (1 << W));
            rs = sx + sy;
        end else begin
            r  = ux - uy;
            c  = (ux >= uy);
            rs = sx - sy;
        end
        s = r[W-1:0];
        v = (rs > (2 ** (W - 1)) - 1) || (rs < -(2 ** (W - 1)));
    endfunction

    // Scoreboard: expected results queued at accept, retired when done appears.
    logic [W-1:0] exp_q[$];
    logic         exp_c_q[$];
    logic         exp_v_q[$];
    int           phase = 0;
    logic [W-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf  = 1'b0;

    always @(posedge clk) begin
        logic [W-1:0] ps;
        logic         pc, pv;
        if (!rst_n) begin
            phase  = 0;
            m_sum  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
            exp_q.delete();
            exp_c_q.delete();
            exp_v_q.delete();
        end else if ((phase == 0 || phase == W + 1) && start) begin
            predict(a, b, mode, ps, pc, pv);
            exp_q.push_back(ps);
            exp_c_q.push_back(pc);
            exp_v_q.push_back(pv);
            phase = 1;
        end else if (phase >= 1 && phase < W) begin
            phase++;
        end else if (phase == W) begin
            if (exp_q.size() > 0) begin
                m_sum  = exp_q.pop_front();
                m_cout = exp_c_q.pop_front();
                m_ovf  = exp_v_q.pop_front();
            end
            phase = W + 1;
        end else begin
            phase = 0;
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        check("busy", busy, 32'(phase >= 1 && phase <= W));
        check("done", done, 32'(phase == W + 1));
        if (phase == 0 || phase == W + 1) check("sum", sum, m_sum);
        check("cout", cout, m_cout);
`ifdef BSA_OVERFLOW_EN
        check("ovf", ovf, m_ovf);
`endif
    end

    // Driver tasks (called at a negedge)
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
        a     = x;
        b     = y;
        mode  = m;
        start = 1'b1;
    endtask

    task automatic wait_done(output int k);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!done && k < 4 * W) begin
            @(negedge clk);
            k++;
        end
        check("done_timeout", done, 1);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                          input logic [W-1:0] es, input logic ec);
        int k;
        @(negedge clk);
        start_op(x, y, m);
        wait_done(k);
        check("latency", k, W + 1);
        check("sum_lit", sum, es);
        check("cout_lit", cout, ec);
    endtask

    initial begin
        int k;
        int n_done;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        rst_n = 1'b1;

        run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
`ifdef BSA_OVERFLOW_EN
        check("ovf_lit_35", ovf, 0);
`endif
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0);
        run_op(8'h20, 8'h10, 1'b1, 8'h10, 1'b1);
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
`ifdef BSA_OVERFLOW_EN
        check("ovf_lit_7f", ovf, 1);
`endif
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1);
`ifdef BSA_OVERFLOW_EN
        check("ovf_lit_80", ovf, 1);
`endif

        // Stray start at N+3 must be ignored; then back-to-back start in DONE.
        @(negedge clk);
        start_op(8'h35, 8'h4A, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start_op(8'hAA, 8'hAA, 1'b0);
        wait_done(k);
        check("ignored_latency", k, W - 2);
        check("ignored_sum", sum, 8'h7F);
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(k);
        check("b2b_latency", k, W + 1);
        check("b2b_sum", sum, 8'h00);
        check("b2b_cout", cout, 1);

        // Reset in cycle N+4 aborts the operation.
        @(negedge clk);
        start_op(8'h35, 8'h4A, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        rst_n = 1'b1;
        n_done = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);

        // Randomized operations, some back-to-back.
        for (int i = 0; i < 60; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            start_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            wait_done(k);
            check("rand_latency", k, W + 1);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
